xgmii_tx_mon: RTL and testbench
===============================

XGMII_TX_MON -- requirements
Module: xgmii_tx_mon

Interface
REQ-001 SHALL have parameter C_LEN_W, default 16, width of frame_len and err_cnt.
REQ-002 SHALL have parameter C_CNT_W, default 32, width of frame_cnt and byte_cnt.
REQ-003 SHALL have port core_clk156_out  in  1  the only clock; all logic on rising edge.
REQ-004 SHALL have port tx_axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port xgmii_txd_dbg  in  64  XGMII TX data, lane k = bits [8k+7:8k], lane 0 first on the wire.
REQ-006 SHALL have port xgmii_txc_dbg  in  8  XGMII TX control, bit k qualifies lane k.
REQ-007 SHALL have port stat_clr  in  1  synchronous clear of frame_cnt, byte_cnt and err_cnt.
REQ-008 SHALL have port in_frame  out  1  high while state is DATA.
REQ-009 SHALL have port frame_done  out  1  one-cycle pulse, frame closed.
REQ-010 SHALL have port frame_len  out  C_LEN_W  length of the closed frame, valid with frame_done.
REQ-011 SHALL have port frame_bad  out  1  closed frame had /E/ or was a runt, valid with frame_done.
REQ-012 SHALL have port proto_err  out  1  one-cycle pulse, protocol violation.
REQ-013 SHALL have port frame_cnt  out  C_CNT_W  count of closed frames, wraps.
REQ-014 SHALL have port byte_cnt  out  C_CNT_W  sum of frame_len over closed frames, wraps.
REQ-015 SHALL have port err_cnt  out  C_LEN_W  count of bad frames plus protocol errors, saturates at all-ones.

Function
REQ-016 SHALL decode control lanes: /S/=0xFB, /T/=0xFD, /E/=0xFE, /I/=0x07; txc bit 0 marks a data lane.
REQ-017 SHALL accept /S/ only in lane 0 or lane 4; /S/ in any other lane SHALL set proto_err and be ignored.
REQ-018 SHALL implement two states, IDLE and DATA; reset state is IDLE.
REQ-019 IDLE->DATA on a valid /S/; the raw count SHALL load 7 for lane 0 and 3 for lane 4, covering the data lanes after /S/.
REQ-020 In DATA, a beat with no control lanes SHALL add 8 to the raw count.
REQ-021 In DATA, /T/ in lane k SHALL add k to the raw count, close the frame and return to IDLE.
REQ-022 On close, frame_len SHALL be raw minus 7 (preamble+SFD), saturating at all-ones; raw < 8 SHALL give frame_len 0 and frame_bad 1.
REQ-023 /E/ in any lane during DATA SHALL latch frame_bad for the current frame; counting continues.
REQ-024 In DATA, a control lane other than /T/ or /E/ SHALL set proto_err, drop the frame without frame_done, and return to IDLE.
REQ-025 In IDLE, /T/ SHALL set proto_err and be ignored.
REQ-026 /S/ in lane 0 during DATA SHALL set proto_err, drop the open frame, and restart the count at 7.
REQ-027 The same beat carrying /T/ in lanes 0-3 and /S/ in lane 4 SHALL close the old frame and open a new one (legal back-to-back); the state SHALL stay DATA.
REQ-028 Registered outputs: frame_done, frame_len, frame_bad and proto_err SHALL assert exactly 1 cycle after the input beat that causes them.
REQ-029 On frame_done, frame_cnt SHALL increment by 1 and byte_cnt by frame_len, modulo 2^C_CNT_W.
REQ-030 err_cnt SHALL increment by 1 per cycle in which frame_bad&frame_done or proto_err is high, saturating; a cycle with both SHALL add 2.
REQ-031 stat_clr SHALL zero the counters on the next edge; an event in the same cycle SHALL be lost, because clear wins.

Reset
REQ-032 While tx_axis_aresetn=0, all outputs and counters SHALL be 0 and the state IDLE, independent of the clock.
REQ-033 Deassertion mid-frame SHALL resume in IDLE; data beats before the next /S/ SHALL be ignored.

Verification
REQ-034 Lane-0 /S/, 8 data beats, /T/ in lane 4 -> raw 7+64+4=75; frame_len=68, frame_bad=0, frame_cnt=1, byte_cnt=68.
REQ-035 Lane-4 /S/, 8 data beats, /T/ in lane 0 of the next beat -> raw 67, frame_len=60, frame_done exactly 1 cycle after the /T/ beat.
REQ-036 Back-to-back: /T/ lane 2 + /S/ lane 4 in one beat -> frame_done 1 cycle later, in_frame stays 1, second frame counted correctly.
REQ-037 /E/ mid-frame -> frame_bad=1 and err_cnt+1; /T/ while IDLE -> proto_err pulse, frame_cnt unchanged.
REQ-038 err_cnt preset near max by 0xFFFF errors -> holds 0xFFFF; stat_clr together with frame_done -> all counters 0.
REQ-039 Reset asserted mid-frame then released, data beats, then /T/ -> no frame_done, proto_err=1.

Source files
------------

// File: rtl/xgmii_tx_mon.sv
// xgmii_tx_mon: XGMII TX frame monitor reporting frame length, errors and statistics
module xgmii_tx_mon #(
  parameter int C_LEN_W = 16,
  parameter int C_CNT_W = 32
) (
  input  logic               core_clk156_out,
  input  logic               tx_axis_aresetn,
  input  logic [63:0]        xgmii_txd_dbg,
  input  logic [7:0]         xgmii_txc_dbg,
  input  logic               stat_clr,
  output logic               in_frame,
  output logic               frame_done,
  output logic [C_LEN_W-1:0] frame_len,
  output logic               frame_bad,
  output logic               proto_err,
  output logic [C_CNT_W-1:0] frame_cnt,
  output logic [C_CNT_W-1:0] byte_cnt,
  output logic [C_LEN_W-1:0] err_cnt
);
  localparam int RW = C_LEN_W + 1;
  localparam int RW1 = RW + 1;
  localparam int LW1 = C_LEN_W + 1;
  localparam logic [7:0] CH_S = 8'hFB, CH_T = 8'hFD, CH_E = 8'hFE;
  typedef enum logic {IDLE, DATA} state_t;
  state_t state, state_nx;
  logic [RW-1:0] raw, raw_nx, raw_fin, raw_sub;
  logic [RW:0] raw_sum;
  logic [LW1-1:0] err_sum;
  logic [C_LEN_W-1:0] len_fin;
  logic [7:0] is_s, is_t, is_e;
  logic [2:0] t_pos;
  logic has_t, has_e, bad_ctl, s_late, s4_after, runt;
  logic bad_q, bad_nx, done_nx, fbad_nx, perr_nx;
  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign is_s[k] = xgmii_txc_dbg[k] && xgmii_txd_dbg[8*k +: 8] == CH_S;
    assign is_t[k] = xgmii_txc_dbg[k] && xgmii_txd_dbg[8*k +: 8] == CH_T;
    assign is_e[k] = xgmii_txc_dbg[k] && xgmii_txd_dbg[8*k +: 8] == CH_E;
  end
  // Lanes before the first /T/ belong to the frame; lanes after it may only start the next one
  always_comb begin
    has_t = 1'b0;
    t_pos = '0;
    has_e = 1'b0;
    bad_ctl = 1'b0;
    s_late = 1'b0;
    s4_after = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!has_t) begin
        has_e = has_e | is_e[k];
        bad_ctl = bad_ctl | (xgmii_txc_dbg[k] & ~is_t[k] & ~is_e[k]);
        t_pos = is_t[k] ? 3'(k) : t_pos;
        has_t = is_t[k];
      end else begin
        s4_after = s4_after | (is_s[k] & (k == 4));
        s_late = s_late | (is_s[k] & (k != 4));
      end
    end
  end
  assign raw_sum = {1'b0, raw} + RW1'(has_t ? {1'b0, t_pos} : 4'd8);
  assign raw_fin = raw_sum[RW] ? '1 : raw_sum[RW-1:0];
  assign raw_sub = raw_fin - RW'(7);
  assign runt = raw_fin < RW'(8);
  assign len_fin = runt ? '0 : raw_sub[RW-1] ? '1 : raw_sub[C_LEN_W-1:0];
  assign in_frame = state == DATA;
  always_comb begin
    state_nx = state;
    raw_nx = raw;
    bad_nx = bad_q;
    done_nx = 1'b0;
    fbad_nx = 1'b0;
    perr_nx = 1'b0;
    if (state == IDLE) begin
      perr_nx = (|is_t) || (|(is_s & 8'hEE));
      if (is_s[0] || is_s[4]) begin
        state_nx = DATA;
        raw_nx = is_s[0] ? RW'(7) : RW'(3);
        bad_nx = 1'b0;
      end
    end else if (is_s[0]) begin
      perr_nx = 1'b1;
      raw_nx = RW'(7);
      bad_nx = 1'b0;
    end else if (bad_ctl) begin
      perr_nx = 1'b1;
      state_nx = IDLE;
    end else if (has_t) begin
      done_nx = 1'b1;
      fbad_nx = bad_q | has_e | runt;
      perr_nx = s_late;
      state_nx = s4_after ? DATA : IDLE;
      raw_nx = RW'(3);
      bad_nx = 1'b0;
    end else begin
      raw_nx = raw_fin;
      bad_nx = bad_q | has_e;
    end
  end
  assign err_sum = {1'b0, err_cnt} + LW1'({1'b0, frame_bad & frame_done} + {1'b0, proto_err});
  always_ff @(posedge core_clk156_out or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      state <= IDLE;
      raw <= '0;
      bad_q <= 1'b0;
      frame_done <= 1'b0;
      frame_len <= '0;
      frame_bad <= 1'b0;
      proto_err <= 1'b0;
      frame_cnt <= '0;
      byte_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      raw <= raw_nx;
      bad_q <= bad_nx;
      frame_done <= done_nx;
      frame_len <= done_nx ? len_fin : '0;
      frame_bad <= fbad_nx;
      proto_err <= perr_nx;
      frame_cnt <= stat_clr ? '0 : frame_done ? frame_cnt + 1'b1 : frame_cnt;
      byte_cnt <= stat_clr ? '0 : frame_done ? byte_cnt + C_CNT_W'(frame_len) : byte_cnt;
      err_cnt <= stat_clr ? '0 : err_sum[C_LEN_W] ? '1 : err_sum[C_LEN_W-1:0];
    end
  end
endmodule

// File: tb/tb_xgmii_tx_mon.sv
// tb_xgmii_tx_mon: directed and randomized checks of xgmii_tx_mon against a byte-stream frame model
module tb_xgmii_tx_mon;
  logic clk = 1'b0, rst_n = 1'b0, stat_clr = 1'b0;
  logic [63:0] txd = {8{8'h07}};
  logic [7:0] txc = 8'hFF;
  logic in_frame, frame_done, frame_bad, proto_err;
  logic [15:0] frame_len, err_cnt;
  logic [31:0] frame_cnt, byte_cnt;
  int tests = 0, fails = 0;
  typedef logic [8:0] beat_t [8];
  typedef struct {int beat; int len; bit bad;} exp_t;
  localparam logic [8:0] SI = 9'h107, SS = 9'h1FB, ST = 9'h1FD, SE = 9'h1FE, D = 9'h055;
  exp_t eq[$];
  logic [8:0] st[$];
  always #5 clk = ~clk;
  xgmii_tx_mon dut (
    .core_clk156_out(clk), .tx_axis_aresetn(rst_n), .xgmii_txd_dbg(txd), .xgmii_txc_dbg(txc),
    .stat_clr(stat_clr), .in_frame(in_frame), .frame_done(frame_done), .frame_len(frame_len),
    .frame_bad(frame_bad), .proto_err(proto_err), .frame_cnt(frame_cnt), .byte_cnt(byte_cnt),
    .err_cnt(err_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Drive one beat from a negedge; returns at the next negedge with that beat's results visible
  task automatic put(input beat_t b);
    for (int k = 0; k < 8; k++) begin
      txd[8*k +: 8] = b[k][7:0];
      txc[k] = b[k][8];
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic beat_t all(input logic [8:0] v);
    beat_t b;
    for (int k = 0; k < 8; k++) b[k] = v;
    return b;
  endfunction
  function automatic beat_t tbeat(input int t);
    beat_t b;
    for (int k = 0; k < 8; k++) b[k] = k < t ? D : k == t ? ST : SI;
    return b;
  endfunction
  function automatic beat_t s0();
    beat_t b = all(D);
    b[0] = SS;
    return b;
  endfunction
  initial begin
    beat_t b;
    int nfr, nby, nerr;
    nfr = 0;
    nby = 0;
    nerr = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_frame", in_frame, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_bad", frame_bad, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_bcnt", byte_cnt, 0);
    chk("rst_ecnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    put(s0());
    chk("s0_in_frame", in_frame, 1);
    repeat (8) put(all(D));
    put(tbeat(4));
    chk("f1_done", frame_done, 1);
    chk("f1_len", frame_len, 68);
    chk("f1_bad", frame_bad, 0);
    chk("f1_in_frame", in_frame, 0);
    put(all(SI));
    chk("f1_done_off", frame_done, 0);
    chk("f1_fcnt", frame_cnt, 1);
    chk("f1_bcnt", byte_cnt, 68);
    b = '{SI, SI, SI, SI, SS, D, D, D};
    put(b);
    repeat (8) put(all(D));
    chk("f2_pre_done", frame_done, 0);
    put(tbeat(0));
    chk("f2_done", frame_done, 1);
    chk("f2_len", frame_len, 60);
    put(all(SI));
    chk("f2_fcnt", frame_cnt, 2);
    chk("f2_bcnt", byte_cnt, 128);
    put(s0());
    repeat (2) put(all(D));
    b = tbeat(2);
    b[4] = SS;
    b[5] = D;
    b[6] = D;
    b[7] = D;
    put(b);
    chk("b2b_done", frame_done, 1);
    chk("b2b_len", frame_len, 18);
    chk("b2b_in_frame", in_frame, 1);
    put(all(D));
    put(tbeat(5));
    chk("b2b2_done", frame_done, 1);
    chk("b2b2_len", frame_len, 9);
    put(all(SI));
    chk("b2b_fcnt", frame_cnt, 4);
    chk("b2b_bcnt", byte_cnt, 155);
    put(s0());
    put(all(D));
    b = all(D);
    b[3] = SE;
    put(b);
    put(tbeat(0));
    chk("e_done", frame_done, 1);
    chk("e_len", frame_len, 16);
    chk("e_bad", frame_bad, 1);
    put(all(SI));
    chk("e_ecnt", err_cnt, 1);
    put(tbeat(3));
    chk("tidle_perr", proto_err, 1);
    chk("tidle_done", frame_done, 0);
    put(all(SI));
    chk("tidle_perr_off", proto_err, 0);
    chk("tidle_ecnt", err_cnt, 2);
    chk("tidle_fcnt", frame_cnt, 5);
    put(s0());
    put(tbeat(0));
    chk("runt_done", frame_done, 1);
    chk("runt_len", frame_len, 0);
    chk("runt_bad", frame_bad, 1);
    put(all(SI));
    chk("runt_ecnt", err_cnt, 3);
    put(s0());
    b = all(D);
    b[2] = SI;
    put(b);
    chk("ictl_perr", proto_err, 1);
    chk("ictl_done", frame_done, 0);
    chk("ictl_in_frame", in_frame, 0);
    put(s0());
    put(all(D));
    put(s0());
    chk("restart_perr", proto_err, 1);
    chk("restart_in_frame", in_frame, 1);
    put(all(D));
    put(tbeat(4));
    chk("restart_len", frame_len, 12);
    put(all(SI));
    chk("restart_ecnt", err_cnt, 5);
    chk("restart_fcnt", frame_cnt, 7);
    chk("restart_bcnt", byte_cnt, 183);
    repeat (65535) put(tbeat(0));
    repeat (2) put(all(SI));
    chk("sat_ecnt", err_cnt, 16'hFFFF);
    put(tbeat(1));
    put(all(SI));
    chk("sat_hold", err_cnt, 16'hFFFF);
    put(s0());
    put(all(D));
    put(tbeat(4));
    chk("clr_done", frame_done, 1);
    stat_clr = 1'b1;
    put(all(SI));
    stat_clr = 1'b0;
    chk("clr_fcnt", frame_cnt, 0);
    chk("clr_bcnt", byte_cnt, 0);
    chk("clr_ecnt", err_cnt, 0);
    put(all(SI));
    chk("clr_lost", frame_cnt, 0);
    put(s0());
    put(all(D));
    rst_n = 1'b0;
    #1;
    chk("arst_in_frame", in_frame, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) put(all(D));
    put(tbeat(4));
    chk("arst_done", frame_done, 0);
    chk("arst_perr", proto_err, 1);
    stat_clr = 1'b1;
    put(all(SI));
    stat_clr = 1'b0;
    for (int f = 0; f < 40; f++) begin
      int n, e, g;
      while (st.size() % 4 != 0) st.push_back(SI);
      g = $urandom_range(0, 2);
      repeat (4 * g) st.push_back(SI);
      st.push_back(SS);
      n = ($urandom_range(0, 4) == 0) ? 7 : $urandom_range(8, 120);
      e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < n; i++) st.push_back(i == e ? SE : {1'b0, 8'($urandom)});
      eq.push_back('{st.size() / 8, n < 8 ? 0 : n - 7, n < 8 || e >= 0});
      nfr++;
      nby += n < 8 ? 0 : n - 7;
      nerr += (n < 8 || e >= 0) ? 1 : 0;
      st.push_back(ST);
    end
    while (st.size() % 8 != 0) st.push_back(SI);
    repeat (16) st.push_back(SI);
    for (int bi = 0; bi < st.size() / 8; bi++) begin
      bit exp_done;
      for (int k = 0; k < 8; k++) b[k] = st[8 * bi + k];
      put(b);
      exp_done = eq.size() > 0 && eq[0].beat == bi;
      chk("rnd_done", frame_done, exp_done);
      chk("rnd_perr", proto_err, 0);
      if (exp_done) begin
        chk("rnd_len", frame_len, eq[0].len);
        chk("rnd_bad", frame_bad, eq[0].bad);
        void'(eq.pop_front());
      end
    end
    chk("rnd_fcnt", frame_cnt, nfr);
    chk("rnd_bcnt", byte_cnt, nby);
    chk("rnd_ecnt", err_cnt, nerr);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
